// File: rtl/gated_d_register.sv
// -----------------------------------------------------------------------------
// gated_d_register
//
// Load-enabled D register with two diagnostic outputs. On each rising edge of
// `clock` the register either resets, loads `new_D` (when `en` is high) or
// holds. It is the basic storage element for datapaths; with the default
// WIDTH=1 it behaves as a single enabled D flip-flop.
//
// Parameters:
//   WIDTH        data width of new_D and Q
//   RESET_VALUE  value Q takes on reset
//   COUNT_WIDTH  width of the saturating load counter
//
// Ports:
//   clock       in   1            system clock, rising edge active
//   reset       in   1            synchronous, active-high reset (beats en)
//   en          in   1            load enable, sampled at the rising edge
//   new_D       in   WIDTH        data captured when en is high
//   Q           out  WIDTH        registered data
//   q_changed   out  1            one-cycle pulse: the last edge's load
//                                 changed Q
//   load_count  out  COUNT_WIDTH  enabled loads since reset, saturating
//
// Handshake: there is none. `en` acts as a valid with no back-pressure; every
// edge with en=1 (and reset=0) is one accepted load.
//
// Every output comes straight from a flop, so nothing on new_D or en reaches an
// output without a clock edge in between.
// -----------------------------------------------------------------------------
module gated_d_register #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic [WIDTH-1:0]       new_D,
   output logic [WIDTH-1:0]       Q,
   output logic                   q_changed,
   output logic [COUNT_WIDTH-1:0] load_count
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   // Comparing against the current Q (not the previous new_D) makes a load of
   // an unchanged value count as a load while leaving q_changed low.
   logic load_differs;
   assign load_differs = (new_D != Q);

   always_ff @(posedge clock) begin
      if (reset) begin
         Q          <= RESET_VALUE;
         q_changed  <= 1'b0;
         load_count <= '0;
      end else if (en) begin
         Q         <= new_D;
         q_changed <= load_differs;
         // Stick at all-ones until the next reset.
         if (load_count != COUNT_MAX) begin
            load_count <= load_count + COUNT_ONE;
         end
      end else begin
         q_changed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gated_d_register.sv
// -----------------------------------------------------------------------------
// tb_gated_d_register
//
// Two instances share clock, reset and en:
//   u_narrow : WIDTH=1, RESET_VALUE=0,     COUNT_WIDTH=2
//   u_wide   : WIDTH=8, RESET_VALUE=8'hA5, COUNT_WIDTH=8
// The driver applies the real inputs at the falling edge and deliberately
// glitches en/new_D shortly after each rising edge. A reference model computes
// the expected post-edge outputs and pushes them into queues; a monitor pops
// them after each rising edge and checks them again mid-cycle.
// -----------------------------------------------------------------------------
module tb_gated_d_register;

   localparam logic [7:0] W_RV    = 8'hA5;
   localparam int         N_MAX   = 3;    // 2^2-1
   localparam int         W_MAX   = 255;  // 2^8-1

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #10 clock = ~clock;

   logic       reset = 1'b1;
   logic       en    = 1'b0;
   logic       d_n   = 1'b0;
   logic [7:0] d_w   = 8'h00;

   logic       q_n;
   logic       chg_n;
   logic [1:0] cnt_n;
   logic [7:0] q_w;
   logic       chg_w;
   logic [7:0] cnt_w;

   gated_d_register #(.WIDTH(1), .RESET_VALUE(1'b0), .COUNT_WIDTH(2)) u_narrow (
      .clock(clock), .reset(reset), .en(en), .new_D(d_n),
      .Q(q_n), .q_changed(chg_n), .load_count(cnt_n)
   );

   gated_d_register #(.WIDTH(8), .RESET_VALUE(W_RV), .COUNT_WIDTH(8)) u_wide (
      .clock(clock), .reset(reset), .en(en), .new_D(d_w),
      .Q(q_w), .q_changed(chg_w), .load_count(cnt_w)
   );

   // ---------------- scoreboard ----------------
   logic [3:0]  exp_n_q[$];   // {Q, q_changed, load_count}
   logic [16:0] exp_w_q[$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // State as the rules describe it: the held value and how many loads have
   // happened since reset; the counter output is that number clipped.
   logic       m_q_n;
   logic [7:0] m_q_w;
   int         loads = 0;

   task automatic model(input logic r, input logic e, input logic dn, input logic [7:0] dw);
      logic chn, chw;
      int   cn, cw;
      chn = 1'b0;
      chw = 1'b0;
      if (r) begin
         m_q_n = 1'b0;
         m_q_w = W_RV;
         loads = 0;
      end else if (e) begin
         chn   = (dn != m_q_n);
         chw   = (dw != m_q_w);
         m_q_n = dn;
         m_q_w = dw;
         loads = loads + 1;
      end
      cn = (loads > N_MAX) ? N_MAX : loads;
      cw = (loads > W_MAX) ? W_MAX : loads;
      exp_n_q.push_back({m_q_n, chn, 2'(cn)});
      exp_w_q.push_back({m_q_w, chw, 8'(cw)});
   endtask

   // ---------------- driver ----------------
   // Just after a rising edge, en is flipped to the opposite of the level that
   // will be sampled and the data is scrambled; the real values go on at the
   // falling edge.
   task automatic drive(input logic r, input logic e, input logic dn, input logic [7:0] dw);
      @(posedge clock);
      #5;
      en  = ~e;
      d_n = 1'($urandom_range(0, 1));
      d_w = 8'($urandom_range(0, 255));
      @(negedge clock);
      reset = r;
      en    = e;
      d_n   = dn;
      d_w   = dw;
      model(r, e, dn, dw);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [3:0]  en_exp;
      logic [16:0] ew_exp;
      forever begin
         @(posedge clock);
         #1;
         if (exp_n_q.size() > 0) begin
            en_exp = exp_n_q.pop_front();
            ew_exp = exp_w_q.pop_front();
            check("narrow_edge", {13'd0, q_n, chg_n, cnt_n}, {13'd0, en_exp});
            check("wide_edge", {q_w, chg_w, cnt_w}, ew_exp);
            #7;  // after the mid-cycle glitch, before the falling edge
            check("narrow_mid", {13'd0, q_n, chg_n, cnt_n}, {13'd0, en_exp});
            check("wide_mid", {q_w, chg_w, cnt_w}, ew_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset with en=1 and data high: reset wins.
      drive(1'b1, 1'b1, 1'b1, 8'hFF);
      // First load after reset.
      drive(1'b0, 1'b1, 1'b1, 8'h3C);
      // Hold for three edges with different data present.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
      // Re-enable: load 0.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      // Same-value loads: count saturates on the narrow counter, no change pulse.
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
      // Reset with en=1, new_D=FF on wide.
      drive(1'b1, 1'b1, 1'b1, 8'hFF);
      // Toggling data under continuous enable.
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'(i), 8'(i * 37));
      // Long enabled run to saturate the wide counter.
      for (int i = 0; i < 280; i++)
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      drive(1'b0, 1'b0, 1'b1, 8'h11);
      // Fully random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)));

      // Drain with a bound.
      for (int i = 0; i < 10 && exp_n_q.size() > 0; i++) @(posedge clock);
      if (exp_n_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_n_q.size());
      end
      repeat (2) @(posedge clock);
      #15;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
